// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch front end: owns the PC and runs a variable-latency req/ack
// handshake to instruction memory, presenting {PCPlus4_F, instr_F} or a bubble.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_F,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] PCPlus4_F,
  output logic [31:0] instr_F,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc_q;
  logic [31:0] r_drain_addr_q;
  logic [31:0] r_buf_q;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_valid;

  assign w_target   = {redirect_pc[31:2], 2'b00};
  assign w_pc_plus4 = r_pc_q + 32'd4;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_pc_q         <= RESET_PC;
      r_drain_addr_q <= 32'd0;
      r_buf_q        <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) r_pc_q <= w_target;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (redirect) begin
            r_pc_q <= w_target;
            // An unacked request cannot be withdrawn; wait it out in DRAIN.
            if (!imem_ack) begin
              r_drain_addr_q <= r_pc_q;
              r_state        <= S_DRAIN;
            end
          end else if (imem_ack) begin
            if (stall_F) begin
              r_buf_q <= imem_rdata;
              r_state <= S_HOLD;
            end else begin
              r_pc_q <= w_pc_plus4;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_pc_q  <= w_target;
            r_state <= S_REQ;
          end else if (!stall_F) begin
            r_pc_q  <= w_pc_plus4;
            r_state <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (redirect) r_pc_q <= w_target;
          if (imem_ack) r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output is assigned a default first, so no latches are inferred.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc_q;
    w_valid   = 1'b0;
    instr_F   = 32'd0;
    case (r_state)
      S_REQ: begin
        imem_req = 1'b1;
        w_valid  = imem_ack & ~redirect;
        instr_F  = imem_rdata;
      end
      S_HOLD: begin
        w_valid = ~redirect;
        instr_F = r_buf_q;
      end
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = r_drain_addr_q;
      end
      default: ;
    endcase
    if (!w_valid) instr_F = 32'd0;
  end

  assign PCPlus4_F  = w_valid ? w_pc_plus4 : 32'd0;
  assign PC_F       = r_pc_q;
  assign fetch_busy = ~w_valid;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed, table-driven bench for fetch_stage_ctrl: one continuous vector run
// from reset plus hand-written reset sequences.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_F;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_F;
  logic [31:0] PCPlus4_F;
  logic [31:0] instr_F;
  logic        fetch_busy;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_F    (stall_F),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .PC_F       (PC_F),
    .PCPlus4_F  (PCPlus4_F),
    .instr_F    (instr_F),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pcf;
    logic [31:0] p4;
    logic [31:0] instr;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic stall, logic redir, logic [31:0] rpc, logic ack,
                              logic [31:0] rdata, logic req, logic [31:0] addr,
                              logic [31:0] pcf, logic [31:0] p4, logic [31:0] instr,
                              logic busy);
    vec_t v;
    v.stall = stall; v.redir = redir; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
    v.req = req; v.addr = addr; v.pcf = pcf; v.p4 = p4; v.instr = instr; v.busy = busy;
    return v;
  endfunction

  function automatic logic [31:0] mem(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check_vec(string name, logic req, logic [31:0] addr, logic [31:0] pcf,
                           logic [31:0] p4, logic [31:0] instr, logic busy);
    n_vec++;
    if (imem_req !== req || imem_addr !== addr || PC_F !== pcf ||
        PCPlus4_F !== p4 || instr_F !== instr || fetch_busy !== busy) begin
      n_err++;
      $display("FAIL %s: got req=%b addr=%h pc=%h p4=%h instr=%h busy=%b; expected req=%b addr=%h pc=%h p4=%h instr=%h busy=%b",
               name, imem_req, imem_addr, PC_F, PCPlus4_F, instr_F, fetch_busy,
               req, addr, pcf, p4, instr, busy);
    end
  endtask

  task automatic drive(logic stall, logic redir, logic [31:0] rpc, logic ack, logic [31:0] rdata);
    stall_F = stall; redirect = redir; redirect_pc = rpc; imem_ack = ack; imem_rdata = rdata;
  endtask

  initial begin
    // stall redir rpc ack rdata | req addr pc p4 instr busy
    vecs.push_back(mk(0,0,0,0,32'h0,                 0,32'h0,32'h0,32'h0,32'h0,1));              // IDLE
    vecs.push_back(mk(0,0,0,1,mem(32'h0),            1,32'h0,32'h0,32'h4,mem(32'h0),0));
    vecs.push_back(mk(0,0,0,1,mem(32'h4),            1,32'h4,32'h4,32'h8,mem(32'h4),0));
    vecs.push_back(mk(1,0,0,1,mem(32'h8),            1,32'h8,32'h8,32'hC,mem(32'h8),0));        // ack + stall
    vecs.push_back(mk(1,0,0,0,32'hDEAD_BEEF,         0,32'h8,32'h8,32'hC,mem(32'h8),0));        // HOLD
    vecs.push_back(mk(1,0,0,0,32'hDEAD_BEEF,         0,32'h8,32'h8,32'hC,mem(32'h8),0));
    vecs.push_back(mk(0,0,0,0,32'hDEAD_BEEF,         0,32'h8,32'h8,32'hC,mem(32'h8),0));        // release
    vecs.push_back(mk(0,0,0,0,32'hDEAD_BEEF,         1,32'hC,32'hC,32'h0,32'h0,1));             // slow ack
    vecs.push_back(mk(1,0,0,0,32'hDEAD_BEEF,         1,32'hC,32'hC,32'h0,32'h0,1));
    vecs.push_back(mk(0,0,0,0,32'hDEAD_BEEF,         1,32'hC,32'hC,32'h0,32'h0,1));
    vecs.push_back(mk(0,0,0,1,mem(32'hC),            1,32'hC,32'hC,32'h10,mem(32'hC),0));
    vecs.push_back(mk(0,1,32'h103,0,32'h0,           1,32'h10,32'h10,32'h0,32'h0,1));           // redirect unacked
    vecs.push_back(mk(0,0,0,0,32'h0,                 1,32'h10,32'h100,32'h0,32'h0,1));          // DRAIN
    vecs.push_back(mk(0,0,0,1,mem(32'h10),           1,32'h10,32'h100,32'h0,32'h0,1));          // drained ack
    vecs.push_back(mk(0,0,0,1,mem(32'h100),          1,32'h100,32'h100,32'h104,mem(32'h100),0));
    vecs.push_back(mk(0,1,32'h200,1,mem(32'h104),    1,32'h104,32'h104,32'h0,32'h0,1));         // redirect + ack
    vecs.push_back(mk(1,0,0,1,mem(32'h200),          1,32'h200,32'h200,32'h204,mem(32'h200),0));
    vecs.push_back(mk(1,1,32'hFFFF_FFFF,0,32'h0,     0,32'h200,32'h200,32'h0,32'h0,1));         // redirect beats stall
    vecs.push_back(mk(0,0,0,1,mem(32'hFFFF_FFFC),    1,32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,mem(32'hFFFF_FFFC),0)); // wrap
    vecs.push_back(mk(0,0,0,0,32'h0,                 1,32'h0,32'h0,32'h0,32'h0,1));
    vecs.push_back(mk(0,1,32'h40,0,32'h0,            1,32'h0,32'h0,32'h0,32'h0,1));
    vecs.push_back(mk(0,1,32'h80,0,32'h0,            1,32'h0,32'h40,32'h0,32'h0,1));            // redirect in DRAIN
    vecs.push_back(mk(0,0,0,0,32'h0,                 1,32'h0,32'h80,32'h0,32'h0,1));

    reset = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
    #2;
    check_vec("reset_state", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      #2;
      check_vec($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].pcf,
                vecs[i].p4, vecs[i].instr, vecs[i].busy);
      @(negedge clk);
    end

    // Asynchronous reset while in DRAIN with ack data on the bus.
    drive(0, 0, 32'h0, 1, 32'h1234_5678);
    #2;
    reset = 1'b0;
    #1;
    check_vec("async_reset_mid_drain", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
    @(posedge clk);
    #1;
    check_vec("reset_held_over_edge", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 32'h0);
    reset = 1'b1;
    #2;
    check_vec("idle_after_release", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
    @(negedge clk);
    #2;
    check_vec("first_req_after_release", 1, 32'h0, 32'h0, 32'h0, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
